// File: rtl/hdlc_line_monitor.sv
// Multi-channel HDLC serial-line monitor: flag/abort/idle detection, destuffed frame sizing, per-channel statistics.
// Latency: FlagDetect/AbortDetect/FrameEnd/FrameErr/IdleLine are registered 1 cycle after the sampled bit; register reads return 1 cycle after ReadEnable.
// Backpressure: none; a bit is consumed on every cycle its RxEN is high. Optional FCS check is enabled by defining HDLC_MON_FCS_EN.
module hdlc_line_monitor #(
  parameter int NUM_CH          = 2,
  parameter int MAX_FRAME_BYTES = 128,
  parameter int CNT_W           = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_CH-1:0]         Rx,
  input  logic [NUM_CH-1:0]         RxEN,
  input  logic [$clog2(NUM_CH)+1:0] Address,
  input  logic                      ReadEnable,
  input  logic                      WriteEnable,
  output logic [CNT_W-1:0]          DataOut,
  output logic [NUM_CH-1:0]         FlagDetect,
  output logic [NUM_CH-1:0]         AbortDetect,
  output logic [NUM_CH-1:0]         IdleLine,
  output logic [NUM_CH-1:0]         FrameEnd,
  output logic [NUM_CH-1:0]         FrameErr
);

  localparam int          ADDR_W = $clog2(NUM_CH) + 2;
  localparam logic [10:0] MAX_B  = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0] SAT_B  = 11'(MAX_FRAME_BYTES + 1);

  typedef enum logic {HUNT, FRAME} state_t;

`ifdef HDLC_MON_FCS_EN
  // One step of the reflected CRC-16-CCITT (poly 0x8408).
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
    crc_bit = (c >> 1) ^ ((c[0] ^ d) ? 16'h8408 : 16'h0000);
  endfunction
`endif

  // Per-channel frame events consumed by the statistics block
  logic [NUM_CH-1:0] w_ev_ok;
  logic [NUM_CH-1:0] w_ev_err;
  logic [NUM_CH-1:0] w_ev_abt;
  logic [10:0]       w_ev_size [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t      r_state, w_state_nxt;
    logic [3:0]  r_ones, w_ones_nxt;
    logic        r_seen_zero, w_seen_zero_nxt;
    logic [10:0] r_b, w_b_nxt, w_b_inc, w_p, w_pbytes, w_size;
    logic        r_idle, w_idle_nxt;
    logic        r_flag, r_abort, r_fend, r_ferr;
    logic        w_flag, w_abort, w_close, w_close_err, w_counted, w_abt_frame;

    assign w_b_inc  = (r_b == 11'h7FF) ? r_b : r_b + 11'd1;
    // Payload bits exclude the first 7 bits of the closing flag
    assign w_p      = r_b - 11'd7;
    assign w_pbytes = {3'b000, w_p[10:3]};
    assign w_size   = (w_pbytes > MAX_B) ? SAT_B : w_pbytes;

`ifdef HDLC_MON_FCS_EN
    logic [15:0] r_crc, w_crc_step, w_crc_nxt;
    logic [7:0]  r_dly, w_dly_nxt;
    logic [3:0]  r_dcnt, w_dcnt_nxt;
    logic        w_fcs_bad;

    // CRC over destuffed bits delayed by 8, so the closing flag never reaches the CRC
    always_comb begin
      w_crc_step = r_crc;
      w_dly_nxt  = r_dly;
      w_dcnt_nxt = r_dcnt;
      if (w_counted || (w_flag && r_state == FRAME)) begin
        w_dly_nxt = {r_dly[6:0], Rx[gi]};
        if (r_dcnt == 4'd8) w_crc_step = crc_bit(r_crc, r_dly[7]);
        else                w_dcnt_nxt = r_dcnt + 4'd1;
      end
      w_crc_nxt = w_crc_step;
      if (w_flag) begin
        w_crc_nxt  = 16'hFFFF;
        w_dly_nxt  = '0;
        w_dcnt_nxt = '0;
      end
    end

    assign w_fcs_bad   = (w_crc_step != 16'hF0B8) || (w_p < 11'd24);
    assign w_close_err = (w_p[2:0] != 3'd0) || (w_pbytes > MAX_B) || w_fcs_bad;

    // CRC state registers
    always_ff @(posedge Clk) begin
      if (!Rst) begin
        r_crc  <= 16'hFFFF;
        r_dly  <= '0;
        r_dcnt <= '0;
      end else begin
        r_crc  <= w_crc_nxt;
        r_dly  <= w_dly_nxt;
        r_dcnt <= w_dcnt_nxt;
      end
    end
`else
    assign w_close_err = (w_p[2:0] != 3'd0) || (w_pbytes > MAX_B);
`endif

    // Bit-step decode and HUNT/FRAME next state
    always_comb begin
      w_state_nxt     = r_state;
      w_ones_nxt      = r_ones;
      w_seen_zero_nxt = r_seen_zero;
      w_b_nxt         = r_b;
      w_idle_nxt      = r_idle;
      w_flag          = 1'b0;
      w_abort         = 1'b0;
      w_close         = 1'b0;
      w_counted       = 1'b0;
      w_abt_frame     = 1'b0;
      if (RxEN[gi]) begin
        if (Rx[gi]) begin
          w_ones_nxt = (r_ones == 4'd8) ? 4'd8 : r_ones + 4'd1;
          w_abort    = (r_ones == 4'd6) && r_seen_zero;
          if (r_ones == 4'd7) w_idle_nxt = 1'b1;
          if (r_state == FRAME) begin
            w_counted = 1'b1;
            if (w_abort) begin
              w_state_nxt = HUNT;
              w_abt_frame = 1'b1;
            end else if (r_ones == 4'd7) begin
              w_state_nxt = HUNT;
            end
          end
        end else begin
          w_ones_nxt      = 4'd0;
          w_seen_zero_nxt = 1'b1;
          w_idle_nxt      = 1'b0;
          if ((r_ones == 4'd6) && r_seen_zero) begin
            w_flag      = 1'b1;
            w_state_nxt = FRAME;
            // b<=7 means back-to-back or shared-zero flags: nothing to report
            w_close     = (r_state == FRAME) && (r_b > 11'd7);
          end else if ((r_state == FRAME) && (r_ones != 4'd5)) begin
            w_counted = 1'b1;
          end
        end
      end
      if (w_counted) w_b_nxt = w_b_inc;
      if (w_flag)    w_b_nxt = '0;
    end

    // Channel state and registered indications
    always_ff @(posedge Clk) begin
      if (!Rst) begin
        r_state     <= HUNT;
        r_ones      <= '0;
        r_seen_zero <= 1'b0;
        r_b         <= '0;
        r_idle      <= 1'b0;
        r_flag      <= 1'b0;
        r_abort     <= 1'b0;
        r_fend      <= 1'b0;
        r_ferr      <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_ones      <= w_ones_nxt;
        r_seen_zero <= w_seen_zero_nxt;
        r_b         <= w_b_nxt;
        r_idle      <= w_idle_nxt;
        r_flag      <= w_flag;
        r_abort     <= w_abort;
        r_fend      <= w_close;
        r_ferr      <= w_close && w_close_err;
      end
    end

    assign w_ev_ok[gi]   = w_close && !w_close_err;
    assign w_ev_err[gi]  = w_close && w_close_err;
    assign w_ev_abt[gi]  = w_abt_frame;
    assign w_ev_size[gi] = w_size;

    assign FlagDetect[gi]  = r_flag;
    assign AbortDetect[gi] = r_abort;
    assign IdleLine[gi]    = r_idle;
    assign FrameEnd[gi]    = r_fend;
    assign FrameErr[gi]    = r_ferr;
  end

  logic [CNT_W-1:0]  r_stat [NUM_CH][4];
  logic [ADDR_W-1:0] w_ch_sel;
  logic [CNT_W-1:0]  w_rd_val;
  logic [CNT_W-1:0]  r_dout;

  assign w_ch_sel = Address >> 2;

  // Saturating statistics; a clear in the same cycle as an update wins
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < 4; k++)
          r_stat[c][k] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ev_ok[c] && (r_stat[c][0] != '1))  r_stat[c][0] <= r_stat[c][0] + CNT_W'(1);
        if (w_ev_err[c] && (r_stat[c][1] != '1)) r_stat[c][1] <= r_stat[c][1] + CNT_W'(1);
        if (w_ev_abt[c] && (r_stat[c][2] != '1)) r_stat[c][2] <= r_stat[c][2] + CNT_W'(1);
        if (w_ev_ok[c] || w_ev_err[c])           r_stat[c][3] <= CNT_W'(w_ev_size[c]);
        for (int k = 0; k < 4; k++)
          if (WriteEnable && (w_ch_sel == ADDR_W'(c)) && (Address[1:0] == 2'(k)))
            r_stat[c][k] <= '0;
      end
    end
  end

  // Read mux; unpopulated channel slots read as zero
  always_comb begin
    w_rd_val = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (w_ch_sel == ADDR_W'(c)) w_rd_val = r_stat[c][Address[1:0]];
  end

  // Read data register samples pre-clear contents and holds until the next read
  always_ff @(posedge Clk) begin
    if (!Rst)            r_dout <= '0;
    else if (ReadEnable) r_dout <= w_rd_val;
  end

  assign DataOut = r_dout;

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Self-checking bench for hdlc_line_monitor: table of framed payloads plus hand-written corner sequences.
// Latency: inputs driven 1 time unit after posedge; pulses counted on negedge; reads take one cycle.
// Backpressure: none; the bench stalls lines only by dropping RxEN.
module tb_hdlc_line_monitor;

  localparam int AW = 3;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [1:0]  Rx = '0;
  logic [1:0]  RxEN = '0;
  logic [AW-1:0] Address = '0;
  logic        ReadEnable = 1'b0;
  logic        WriteEnable = 1'b0;
  logic [15:0] DataOut;
  logic [1:0]  FlagDetect, AbortDetect, IdleLine, FrameEnd, FrameErr;

  hdlc_line_monitor #(.NUM_CH(2), .MAX_FRAME_BYTES(128), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN), .Address(Address),
    .ReadEnable(ReadEnable), .WriteEnable(WriteEnable), .DataOut(DataOut),
    .FlagDetect(FlagDetect), .AbortDetect(AbortDetect), .IdleLine(IdleLine),
    .FrameEnd(FrameEnd), .FrameErr(FrameErr)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;
  int flag_cnt [2];
  int abort_cnt[2];
  int fend_cnt [2];
  int ferr_last[2];
  int tx_ones;
  int exp_ok [2];
  int exp_err[2];
  int exp_abt[2];
  int exp_sz [2];

  // Pulse counters sampled mid-cycle
  always @(negedge Clk) begin
    for (int c = 0; c < 2; c++) begin
      if (FlagDetect[c])  flag_cnt[c]++;
      if (AbortDetect[c]) abort_cnt[c]++;
      if (FrameEnd[c]) begin
        fend_cnt[c]++;
        ferr_last[c] = int'(FrameErr[c]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_bit(input int ch, input logic b);
    RxEN = '0;
    Rx[ch] = b;
    RxEN[ch] = 1'b1;
    @(posedge Clk); #1;
    RxEN = '0;
  endtask

  task automatic idle_cycles(input int n);
    RxEN = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  // Raw flag 01111110; clr asserts a frames_ok clear with the final flag bit
  task automatic send_flag(input int ch, input logic clr);
    send_bit(ch, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(ch, 1'b1);
    if (clr) begin
      Address = AW'(ch * 4);
      WriteEnable = 1'b1;
    end
    send_bit(ch, 1'b0);
    WriteEnable = 1'b0;
    tx_ones = 0;
  endtask

  // LSB-first payload with a stuffed 0 after every five consecutive 1s
  task automatic send_payload(input int ch, input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(ch, data[i]);
      if (data[i]) begin
        tx_ones++;
        if (tx_ones == 5) begin
          send_bit(ch, 1'b0);
          tx_ones = 0;
        end
      end else begin
        tx_ones = 0;
      end
    end
  endtask

  task automatic rd(input int ch, input int idx, output int v);
    Address = AW'(ch * 4 + idx);
    ReadEnable = 1'b1;
    @(posedge Clk); #1;
    ReadEnable = 1'b0;
    v = int'(DataOut);
  endtask

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          nbits;
    logic        exp_err;
    int          exp_size;
  } vec_t;

  vec_t vt[6];

  initial begin
    int v, c, f0, e0, a0;

    vt[0] = '{0, 32'h00030201, 24, 1'b0, 3};
    vt[1] = '{0, 32'h000000FF,  8, 1'b0, 1};
    vt[2] = '{0, 32'h00000ABC, 12, 1'b1, 1};
    vt[3] = '{1, 32'h00007E7E, 16, 1'b0, 2};
    vt[4] = '{1, 32'h00000005,  7, 1'b1, 0};
    vt[5] = '{0, 32'h0000FFFF, 16, 1'b0, 2};

    // Reset state
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset FlagDetect",  int'(FlagDetect), 0);
    chk("reset AbortDetect", int'(AbortDetect), 0);
    chk("reset IdleLine",    int'(IdleLine), 0);
    chk("reset FrameEnd",    int'(FrameEnd), 0);
    chk("reset DataOut",     int'(DataOut), 0);
    Rst = 1'b1;

    // Idle line: 20 ones on both channels
    Rx = 2'b11;
    for (int i = 1; i <= 20; i++) begin
      RxEN = 2'b11;
      @(posedge Clk); #1;
      if (i == 7)  chk("idle after 7 ones", int'(IdleLine), 0);
      if (i == 8)  chk("idle after 8 ones", int'(IdleLine), 3);
      if (i == 20) chk("idle after 20 ones", int'(IdleLine), 3);
    end
    idle_cycles(2);
    chk("idle no flags",  flag_cnt[0] + flag_cnt[1], 0);
    chk("idle no aborts", abort_cnt[0] + abort_cnt[1], 0);
    for (int ch = 0; ch < 2; ch++)
      for (int idx = 0; idx < 4; idx++) begin
        rd(ch, idx, v);
        chk($sformatf("idle counter ch%0d idx%0d", ch, idx), v, 0);
      end

    // Table of framed payloads
    for (int k = 0; k < 6; k++) begin
      c  = vt[k].ch;
      f0 = flag_cnt[c];
      e0 = fend_cnt[c];
      send_flag(c, 1'b0);
      send_payload(c, vt[k].data, vt[k].nbits);
      send_flag(c, 1'b0);
      idle_cycles(2);
      chk($sformatf("row%0d flags", k), flag_cnt[c] - f0, 2);
      chk($sformatf("row%0d frame_end", k), fend_cnt[c] - e0, 1);
      chk($sformatf("row%0d frame_err", k), ferr_last[c], int'(vt[k].exp_err));
      if (vt[k].exp_err) exp_err[c]++;
      else               exp_ok[c]++;
      exp_sz[c] = vt[k].exp_size;
      rd(c, 3, v); chk($sformatf("row%0d last_size", k), v, exp_sz[c]);
      rd(c, 0, v); chk($sformatf("row%0d frames_ok", k), v, exp_ok[c]);
      rd(c, 1, v); chk($sformatf("row%0d frames_err", k), v, exp_err[c]);
      if (k == 0)
        for (int idx = 0; idx < 4; idx++) begin
          rd(1, idx, v);
          chk($sformatf("ch1 untouched idx%0d", idx), v, 0);
        end
    end

    // Three stalled cycles mid-frame with Rx toggling must not disturb the frame
    e0 = fend_cnt[0];
    send_flag(0, 1'b0);
    send_payload(0, 32'h01, 8);
    for (int i = 0; i < 3; i++) begin
      Rx = (i % 2 == 0) ? 2'b01 : 2'b10;
      idle_cycles(1);
    end
    send_payload(0, 32'h0302, 16);
    send_flag(0, 1'b0);
    idle_cycles(2);
    exp_ok[0]++;
    exp_sz[0] = 3;
    chk("stall frame_end", fend_cnt[0] - e0, 1);
    chk("stall frame_err", ferr_last[0], 0);
    rd(0, 3, v); chk("stall last_size", v, 3);
    rd(0, 0, v); chk("stall frames_ok", v, exp_ok[0]);

    // Clear frames_ok on the same cycle a good frame closes
    e0 = fend_cnt[0];
    send_flag(0, 1'b0);
    send_payload(0, 32'h01, 8);
    send_flag(0, 1'b1);
    idle_cycles(2);
    exp_ok[0] = 0;
    exp_sz[0] = 1;
    chk("clear-vs-inc frame_end", fend_cnt[0] - e0, 1);
    rd(0, 0, v); chk("clear-vs-inc frames_ok", v, 0);

    // Read and clear last_size in the same cycle
    Address = AW'(3);
    ReadEnable = 1'b1;
    WriteEnable = 1'b1;
    @(posedge Clk); #1;
    ReadEnable = 1'b0;
    WriteEnable = 1'b0;
    chk("rd+wr same cycle old value", int'(DataOut), 1);
    exp_sz[0] = 0;
    rd(0, 3, v); chk("rd after clear", v, 0);

    // Abort after 5 bytes: 0 then seven 1s
    a0 = abort_cnt[0];
    e0 = fend_cnt[0];
    send_flag(0, 1'b0);
    for (int i = 0; i < 5; i++) send_payload(0, 32'hA5, 8);
    send_bit(0, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(0, 1'b1);
    idle_cycles(2);
    exp_abt[0]++;
    chk("abort pulse", abort_cnt[0] - a0, 1);
    chk("abort no frame_end", fend_cnt[0] - e0, 0);
    rd(0, 2, v); chk("abort frames_aborted", v, exp_abt[0]);

    // Opening flag after abort comes from HUNT: no frame report
    send_flag(0, 1'b0);
    idle_cycles(2);
    chk("post-abort open no frame_end", fend_cnt[0] - e0, 0);

    // 128-byte frame: largest good payload
    for (int i = 0; i < 128; i++) send_payload(0, 32'h55, 8);
    send_flag(0, 1'b0);
    idle_cycles(2);
    exp_ok[0]++;
    exp_sz[0] = 128;
    chk("128B frame_end", fend_cnt[0] - e0, 1);
    chk("128B frame_err", ferr_last[0], 0);
    rd(0, 3, v); chk("128B last_size", v, 128);

    // 129-byte frame overflows
    e0 = fend_cnt[0];
    send_flag(0, 1'b0);
    for (int i = 0; i < 129; i++) send_payload(0, 32'h55, 8);
    send_flag(0, 1'b0);
    idle_cycles(2);
    exp_err[0]++;
    exp_sz[0] = 129;
    chk("129B frame_end", fend_cnt[0] - e0, 1);
    chk("129B frame_err", ferr_last[0], 1);
    rd(0, 3, v); chk("129B last_size", v, 129);
    rd(0, 1, v); chk("129B frames_err", v, exp_err[0]);

    // Final statistics for both channels
    for (int ch = 0; ch < 2; ch++) begin
      rd(ch, 0, v); chk($sformatf("final ch%0d frames_ok", ch), v, exp_ok[ch]);
      rd(ch, 1, v); chk($sformatf("final ch%0d frames_err", ch), v, exp_err[ch]);
      rd(ch, 2, v); chk($sformatf("final ch%0d frames_aborted", ch), v, exp_abt[ch]);
      rd(ch, 3, v); chk($sformatf("final ch%0d last_size", ch), v, exp_sz[ch]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hdlc_line_monitor.md
Name: hdlc_line_monitor

Overview:
- Synthesizable, multi-channel HDLC serial-line monitor. It replaces simulation-only protocol checking with counters and flags that can be read back in silicon.
- Each channel watches one bit-serial HDLC line (Rx or Tx side of an HDLC instance). Per bit it detects flag, abort, idle and stuffed zeros, and counts destuffed frame bytes.
- At each frame end it classifies the frame as good, error (misaligned or overflow) or aborted, and updates per-channel saturating counters.
- Counters are readable and clearable through a small register port.

Parameters:
- NUM_CH, 2, number of monitored serial lines (1..8).
- MAX_FRAME_BYTES, 128, payload byte limit; above this the frame overflows.
- CNT_W, 16, width of each statistics counter.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  synchronous reset, active-low.
- Rx  input  NUM_CH  serial bit per channel.
- RxEN  input  NUM_CH  bit-valid strobe per channel; Rx[i] is sampled only when RxEN[i]=1.
- Address  input  $clog2(NUM_CH)+2  register select {channel, index}.
- ReadEnable  input  1  register read strobe.
- WriteEnable  input  1  register clear strobe.
- DataOut  output  CNT_W  read data.
- FlagDetect  output  NUM_CH  1-cycle pulse per detected flag.
- AbortDetect  output  NUM_CH  1-cycle pulse per detected abort.
- IdleLine  output  NUM_CH  level, high while the line is idle.
- FrameEnd  output  NUM_CH  1-cycle pulse when a frame is classified.
- FrameErr  output  NUM_CH  qualifies FrameEnd; 1 means error frame.

Behaviour:
- Reset (Rst=0 at posedge): state HUNT, ones_cnt=0, seen_zero=0, bit/byte counters=0, all statistics counters=0, and all outputs 0.
- Per-channel bit step. Occurs only on cycles with RxEN[i]=1; channels are fully independent.
  - ones_cnt counts consecutive 1s and saturates at 8.
  - A 0 bit clears ones_cnt and sets seen_zero.
- Flag: a 0 arrives with ones_cnt==6 and seen_zero=1. FlagDetect pulses in the next cycle (registered, latency 1).
- Abort: ones_cnt goes 6->7 with seen_zero=1. AbortDetect pulses the next cycle.
- IdleLine: set when ones_cnt reaches 8; cleared on the cycle after the next 0 bit.
- States: HUNT, FRAME.
  - HUNT -> FRAME on flag. Bit counter b is cleared and bytes is cleared.
  - FRAME + flag:
    - If b<=7 (back-to-back flags or shared-zero flags): no report, stay in FRAME, clear b.
    - Otherwise the frame closes. Payload bits p = b-7. FrameEnd pulses. FrameErr=1 if p%8!=0 or overflow. The matching counter increments, last_size is updated, and the channel stays in FRAME (the closing flag opens the next frame).
  - FRAME + abort: aborted counter increments, FrameEnd stays 0, go to HUNT.
  - FRAME + ones_cnt reaching 8: handled as abort (already counted); stay in HUNT.
- Zero destuffing, in FRAME only: a 0 arriving with ones_cnt==5 is a stuffed zero. It is not counted in b and clears ones_cnt.
- Bit counting:
  - b counts every non-stuffed bit in FRAME, including the first 7 bits of the closing flag; the closing 0 is excluded. b is 11 bits wide and saturates.
  - bytes = number of completed octets, saturating at MAX_FRAME_BYTES+1.
  - overflow = bytes > MAX_FRAME_BYTES after subtracting the closing flag's contribution, i.e. (b-7)/8 > MAX_FRAME_BYTES.
- Statistics, per channel, index 0..3:
  - 0 frames_ok
  - 1 frames_err
  - 2 frames_aborted
  - 3 last_size, the payload bytes of the last closed frame: p/8, saturating at MAX_FRAME_BYTES+1, zero-extended to CNT_W.
  - All counters saturate at all-ones and never wrap.
- Register port:
  - ReadEnable: DataOut = selected register one cycle later, held until the next read. A channel index >= NUM_CH reads 0.
  - WriteEnable clears the selected register.
  - Read and write to the same address in the same cycle: returns the pre-clear value.
  - Clear in the same cycle as an increment: clear wins, result 0.
- Reset mid-frame discards the frame, with no counter update.

Optional Feature:
- Macro: HDLC_MON_FCS_EN.
- When defined, each channel runs a reflected CRC-16-CCITT (poly 0x8408, init 0xFFFF) over destuffed FRAME bits. The CRC is re-initialised on every flag. Each bit is committed only once it is 8 non-stuffed bits old, so that closing-flag bits are excluded.
- At frame close, the frame is also an error if the residue != 0xF0B8, or if p < 24 (shorter than 1 data byte plus 2 FCS bytes).
- Undefined: no CRC logic; FCS bytes are counted as ordinary payload.

Test Plan:
- Reset, then 20 cycles of Rx=1 with RxEN=1 -> IdleLine=1 from the cycle after the 8th one; FlagDetect=0; all counters read 0.
- Flag, 3 bytes 0x01 0x02 0x03, flag on ch0 -> two FlagDetect pulses, FrameEnd=1 with FrameErr=0, frames_ok=1, last_size=3; ch1 counters stay 0.
- Payload byte 0xFF (requires a stuffed zero after 5 ones) -> last_size=1 and FrameErr=0, showing the stuffed zero was not counted.
- Flag, 12 payload bits, flag -> FrameErr=1, frames_err=1, last_size=1.
- Flag, 5 bytes, then 0 followed by 7 ones -> AbortDetect pulse, frames_aborted=1, no FrameEnd, state HUNT. Then 129 bytes framed by flags -> frames_err increments and last_size=129.
- Write-clear frames_ok in the same cycle a good frame closes -> read returns 0. Read/write at the same address returns the old value. RxEN=0 for 3 cycles mid-frame -> result is identical to the unstalled frame.
